// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deserialises 11-bit frames,
// checks start/parity/stop and queues good scan-code bytes in a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]         s;
    logic [1:0]         d;
    logic [9:0]         sbuf;
    logic [3:0]         cnt;
    logic [TW-1:0]      idle;
    logic [FIFO_AW-1:0] w_ptr, r_ptr;
    logic [7:0]         mem [DEPTH];

    logic fall, full, pop, good, timeout;

    assign fall    = s[2] & ~s[1];
    assign full    = FIFO_AW'(w_ptr + 1'b1) == r_ptr;
    assign ready   = w_ptr != r_ptr;
    assign data    = mem[r_ptr];
    assign pop     = ready & ~nextdata_n;
    // sbuf holds start..parity; the stop bit is sampled live on the judging fall
    assign good    = ~sbuf[0] & d[1] & (^sbuf[9:1]);
    assign timeout = (cnt != 4'd0) & ~fall & (idle == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s         <= 3'b111;
            d         <= 2'b11;
            sbuf      <= '0;
            cnt       <= '0;
            idle      <= '0;
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            s         <= {s[1:0], ps2_clk};
            d         <= {d[0], ps2_data};
            frame_err <= 1'b0;
            if (pop) r_ptr <= r_ptr + 1'b1;
            if (fall) begin
                idle <= '0;
                if (cnt == 4'd10) begin
                    cnt <= '0;
                    if (!good)     frame_err <= 1'b1;
                    else if (full) overflow  <= 1'b1;
                    else begin
                        mem[w_ptr] <= sbuf[8:1];
                        w_ptr      <= w_ptr + 1'b1;
                    end
                end else begin
                    sbuf <= {d[1], sbuf[9:1]};
                    cnt  <= cnt + 1'b1;
                end
            end else if (cnt != 4'd0) begin
                // keyboard stalled mid-frame: abandon it so the next start bit resyncs
                if (timeout) begin
                    cnt       <= '0;
                    idle      <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle <= idle + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: stimulus queues expected bytes, a negedge monitor
// checks every popped byte and the width of every frame_err pulse.
module tb_ps2_kbd_rx;
    localparam int H = 30;

    logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int         tests = 0, fails = 0, errs = 0, e0, lat;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic       prev_err = 1'b0;

    ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT_CYC(2000)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready && !nextdata_n) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", data);
            end else begin
                mon_exp = sb.pop_front();
                if (data !== mon_exp) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", data, mon_exp);
                end
            end
        end
        if (frame_err) begin
            errs++;
            tests++;
            if (prev_err) begin
                fails++;
                $display("FAIL frame_err_width: got 2+ cycles expected 1");
            end
        end
        prev_err = frame_err;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_send(input logic [7:0] b, input bit flip, input int nbits,
                            input bit pop_w, output int l);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        l = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            clks(H);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int k = 1; k <= H; k++) begin
                    clks(1);
                    if (pop_w && k == 2) nextdata_n = 1'b0;
                    if (pop_w && k == 3) nextdata_n = 1'b1;
                    if (l < 0 && ready) l = k;
                end
            end else begin
                clks(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        clks(2 * H);
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        sb.push_back(b);
        ps2_send(b, 1'b0, 11, 1'b0, l);
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            nextdata_n = 1'b0;
            clks(1);
            nextdata_n = 1'b1;
            clks(1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clks(3);
        chk("rst_ready", ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_data", data, 8'h00);
        clrn = 1'b1;
        clks(2);

        // single frame, latency and pop
        sb.push_back(8'h1C);
        ps2_send(8'h1C, 1'b0, 11, 1'b0, lat);
        chk("t1_latency_ok", (lat >= 1 && lat <= 4), 1);
        chk("t1_ready", ready, 1);
        chk("t1_data", data, 8'h1C);
        pop_n(1);
        chk("t1_ready_after_pop", ready, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // three queued bytes in order
        e0 = errs;
        send(8'hF0); send(8'h1C); send(8'h29);
        chk("t2_ready", ready, 1);
        pop_n(3);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_ready_end", ready, 0);
        chk("t2_no_err", errs, e0);

        // parity error then recovery
        e0 = errs;
        ps2_send(8'h1C, 1'b1, 11, 1'b0, lat);
        chk("t3_err_pulse", errs, e0 + 1);
        chk("t3_ready", ready, 0);
        send(8'h32);
        chk("t3_data", data, 8'h32);
        pop_n(1);
        chk("t3_sb_empty", sb.size(), 0);

        // mid-frame timeout then recovery
        e0 = errs;
        ps2_send(8'hAA, 1'b0, 5, 1'b0, lat);
        clks(2300);
        chk("t5_timeout_err", errs, e0 + 1);
        chk("t5_ready", ready, 0);
        send(8'h5A);
        chk("t5_data", data, 8'h5A);
        pop_n(1);
        chk("t5_sb_empty", sb.size(), 0);

        // overflow: 8 frames into 7 slots
        e0 = errs;
        for (int i = 1; i <= 8; i++) begin
            if (i <= 7) sb.push_back(8'(i));
            ps2_send(8'(i), 1'b0, 11, 1'b0, lat);
        end
        chk("t4_overflow", overflow, 1);
        pop_n(7);
        chk("t4_ready_end", ready, 0);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_no_err", errs, e0);

        // reset mid-frame
        ps2_send(8'h55, 1'b0, 6, 1'b0, lat);
        clrn = 1'b0;
        clks(2);
        chk("t6_ready", ready, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_frame_err", frame_err, 0);
        chk("t6_data", data, 8'h00);
        clrn = 1'b1;
        clks(2);
        e0 = errs;
        send(8'h33);
        chk("t6_data_after", data, 8'h33);
        pop_n(1);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_no_err", errs, e0);

        // full FIFO, pop coincides with the dropped write
        for (int i = 1; i <= 7; i++) send(8'(8'h40 + i));
        chk("t7_overflow_before", overflow, 0);
        ps2_send(8'h99, 1'b0, 11, 1'b1, lat);
        chk("t7_overflow", overflow, 1);
        chk("t7_head", data, 8'h42);
        pop_n(6);
        chk("t7_ready_end", ready, 0);
        chk("t7_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
